dmadd_seq: RTL and testbench

DMADD_SEQ -- requirements
Module: dmadd_seq

---
 rtl/dmadd_seq_if.sv | 31 +++
 rtl/dmadd_seq.sv | 76 +++++++
 tb/tb_dmadd_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmadd_seq_if.sv
// Load, datapath and result buses of the dmadd job sequencer.
// slave is the sequencer's view; master is the load source / datapath / result sink.
interface dmadd_seq_if;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_index;
   logic [3:0]  ld_data;
   logic        ld_last;
   logic        dp_rst_n;
   logic [3:0]  dp_index;
   logic [3:0]  dp_data;
   logic [1:0]  dp_insn;
   logic        dp_load;
   logic        dp_run;
   logic [11:0] dp_out;
   logic        res_valid;
   logic [11:0] res_data;
   logic        res_ready;

   modport slave (
      input  ld_valid, ld_index, ld_data, ld_last, dp_out, res_ready,
      output ld_ready, dp_rst_n, dp_index, dp_data, dp_insn, dp_load, dp_run,
             res_valid, res_data
   );

   modport master (
      output ld_valid, ld_index, ld_data, ld_last, dp_out, res_ready,
      input  ld_ready, dp_rst_n, dp_index, dp_data, dp_insn, dp_load, dp_run,
             res_valid, res_data
   );
endinterface

// File: rtl/dmadd_seq.sv
// Job sequencer for the dmadd datapath: clear, stream load beats, run for a
// fixed count, settle, then hold the captured result until consumed.
module dmadd_seq #(
   parameter int RUN_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] cfg_insn,
   output logic       busy,
   output logic       err,
   dmadd_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, INIT, LOAD, RUN, SETTLE, RESULT} state_t;

   localparam logic [7:0] RUN_LD    = 8'(RUN_CYCLES - 1);
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

   state_t     state, nxt;
   logic [7:0] cnt;
   logic [1:0] job;
   logic       beat, go, bad_insn;

   assign beat     = (state == LOAD) && bus.ld_valid;
   assign bad_insn = (cfg_insn == 2'b11);
   assign go       = (state == IDLE) && start && !bad_insn;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (go) nxt = CLEAR;
         CLEAR:   nxt = INIT;
         INIT:    nxt = LOAD;
         LOAD:    if (beat && bus.ld_last) nxt = RUN;
         RUN:     if (cnt == 8'd0) nxt = SETTLE;
         SETTLE:  if (cnt == 8'd0) nxt = RESULT;
         RESULT:  if (bus.res_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         job          <= 2'b00;
         bus.res_data <= 12'd0;
         err          <= 1'b0;
      end else begin
         state <= nxt;
         if (go) job <= cfg_insn;
         // One counter serves both RUN and SETTLE; each phase reloads it on entry.
         if (beat && bus.ld_last)
            cnt <= RUN_LD;
         else if (state == RUN && cnt == 8'd0)
            cnt <= SETTLE_LD;
         else if ((state == RUN || state == SETTLE) && cnt != 8'd0)
            cnt <= cnt - 8'd1;
         if (state == SETTLE && cnt == 8'd0) bus.res_data <= bus.dp_out;
         if ((start && (state != IDLE || bad_insn)) || (bus.ld_valid && state != LOAD))
            err <= 1'b1;
      end
   end

   assign busy         = (state != IDLE);
   assign bus.ld_ready = (state == LOAD);
   // Datapath reset follows rst directly so it stays asserted for the whole reset.
   assign bus.dp_rst_n = !rst && (state != CLEAR);
   assign bus.dp_insn  = (state == IDLE) ? 2'b00 : job;
   assign bus.dp_load  = beat;
   assign bus.dp_index = beat ? bus.ld_index : 4'd0;
   assign bus.dp_data  = beat ? bus.ld_data  : 4'd0;
   assign bus.dp_run   = (state == RUN);
   assign bus.res_valid = (state == RESULT);
endmodule

// File: tb/tb_dmadd_seq.sv
// Directed bench for dmadd_seq with a result scoreboard and a per-cycle monitor.
module tb_dmadd_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cfg_insn = 2'b00;
   logic       busy, err;

   dmadd_seq_if bus();

   dmadd_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cfg_insn (cfg_insn),
      .busy     (busy),
      .err      (err),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int run_cnt, rdy_cnt, load_cnt;
   logic [1:0]  job_insn = 2'b00;
   logic [11:0] exp_q[$];
   logic [3:0]  idx_q[$];
   logic [3:0]  bi[4];
   logic [3:0]  bd[4];

   // Datapath stand-in: its output is the count of clock edges so far.
   always @(posedge clk) cyc <= cyc + 1;
   assign bus.dp_out = 12'(cyc);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.dp_run)   run_cnt++;
         if (bus.ld_ready) rdy_cnt++;
         if (bus.dp_load) begin
            load_cnt++;
            idx_q.push_back(bus.dp_index);
         end else
            chk("dp_idx_data_zero", {24'd0, bus.dp_index, bus.dp_data}, 32'd0);
         if (busy) chk("dp_insn_job", {30'd0, bus.dp_insn}, {30'd0, job_insn});
         else      chk("dp_insn_idle", {30'd0, bus.dp_insn}, 32'd0);
         if (bus.res_valid && bus.res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got result %0h expected none", bus.res_data);
            end else begin
               logic [11:0] e;
               e = exp_q.pop_front();
               if (bus.res_data !== e) begin
                  errors++;
                  $display("FAIL res_data: got %0h expected %0h", bus.res_data, e);
               end
            end
         end
      end
   end

   task automatic do_job(input logic [1:0] insn, input int nb, input bit gap, input int bp,
                         input bit poke, input string nm);
      int edges, g, lat;
      logic [11:0] held;
      g   = gap ? nb - 1 : 0;
      lat = 3 + nb + g + 16 + 1;
      run_cnt = 0; rdy_cnt = 0; load_cnt = 0;
      idx_q.delete();
      job_insn = insn;
      exp_q.push_back(12'(cyc + lat - 1));
      start = 1'b1; cfg_insn = insn;
      @(posedge clk); #1 start = 1'b0; edges = 1;
      while (!bus.ld_ready && edges < 20) begin @(posedge clk); #1 edges++; end
      chk({nm, "_load_entry"}, edges, 3);
      for (int i = 0; i < nb; i++) begin
         bus.ld_valid = 1'b1; bus.ld_index = bi[i]; bus.ld_data = bd[i];
         bus.ld_last = (i == nb - 1);
         @(posedge clk); #1 edges++;
         bus.ld_valid = 1'b0; bus.ld_index = 4'd0; bus.ld_data = 4'd0; bus.ld_last = 1'b0;
         if (gap && i < nb - 1) begin @(posedge clk); #1 edges++; end
      end
      while (!bus.res_valid && edges < 400) begin
         @(posedge clk); #1 edges++;
         if (poke && edges == 3 + nb + g + 5) begin start = 1'b1; cfg_insn = 2'b00; end
         else start = 1'b0;
      end
      start = 1'b0;
      chk({nm, "_latency"}, edges, lat);
      chk({nm, "_run_cycles"}, run_cnt, 16);
      chk({nm, "_ld_ready_cycles"}, rdy_cnt, nb + g);
      chk({nm, "_load_pulses"}, load_cnt, nb);
      if (idx_q.size() == nb)
         for (int i = 0; i < nb; i++) chk({nm, "_dp_index"}, {28'd0, idx_q[i]}, {28'd0, bi[i]});
      held = bus.res_data;
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         chk({nm, "_bp_valid"}, {31'd0, bus.res_valid}, 32'd1);
         chk({nm, "_bp_data"}, {20'd0, bus.res_data}, {20'd0, held});
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1 bus.res_ready = 1'b0;
      chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_idle_valid"}, {31'd0, bus.res_valid}, 32'd0);
      chk({nm, "_retain"}, {20'd0, bus.res_data}, {20'd0, held});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.ld_valid = 1'b0; bus.ld_index = 4'd0; bus.ld_data = 4'd0; bus.ld_last = 1'b0;
      bus.res_ready = 1'b0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
      chk("rst_dp_rst_n", {31'd0, bus.dp_rst_n}, 32'd0);
      chk("rst_dp_load", {31'd0, bus.dp_load}, 32'd0);
      chk("rst_dp_run", {31'd0, bus.dp_run}, 32'd0);
      chk("rst_dp_idx_data", {24'd0, bus.dp_index, bus.dp_data}, 32'd0);
      chk("rst_dp_insn", {30'd0, bus.dp_insn}, 32'd0);
      chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("rst_res_data", {20'd0, bus.res_data}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      bi[0] = 4'd5; bd[0] = 4'd3; bi[1] = 4'd9; bd[1] = 4'd2;
      do_job(2'b10, 2, 1'b0, 10, 1'b0, "madd");
      bi[0] = 4'd4; bd[0] = 4'd7;
      do_job(2'b00, 1, 1'b0, 0, 1'b0, "min");
      bi[0] = 4'd1; bd[0] = 4'd8; bi[1] = 4'd2; bd[1] = 4'd9; bi[2] = 4'd3; bd[2] = 4'd10;
      do_job(2'b10, 3, 1'b1, 2, 1'b0, "gapped");
      chk("no_spurious_err", {31'd0, err}, 32'd0);

      start = 1'b1; cfg_insn = 2'b11;
      @(posedge clk); #1 start = 1'b0;
      chk("illegal_err", {31'd0, err}, 32'd1);
      chk("illegal_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("illegal_stays_idle", {31'd0, busy}, 32'd0);
      do_reset();

      bi[0] = 4'd6; bd[0] = 4'd1; bi[1] = 4'd7; bd[1] = 4'd15;
      do_job(2'b01, 2, 1'b0, 0, 1'b1, "start_in_run");
      chk("start_in_run_err", {31'd0, err}, 32'd1);
      do_reset();

      bus.ld_valid = 1'b1;
      @(posedge clk); #1 bus.ld_valid = 1'b0;
      chk("ld_idle_err", {31'd0, err}, 32'd1);
      chk("ld_idle_busy", {31'd0, busy}, 32'd0);
      do_reset();

      job_insn = 2'b10;
      start = 1'b1; cfg_insn = 2'b10;
      @(posedge clk); #1 start = 1'b0;
      w = 0;
      while (!bus.ld_ready && w < 20) begin @(posedge clk); #1 w++; end
      bus.ld_valid = 1'b1; bus.ld_index = 4'd2; bus.ld_data = 4'd5; bus.ld_last = 1'b1;
      @(posedge clk); #1;
      bus.ld_valid = 1'b0; bus.ld_index = 4'd0; bus.ld_data = 4'd0; bus.ld_last = 1'b0;
      chk("abort_in_run", {31'd0, bus.dp_run}, 32'd1);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_dp_run", {31'd0, bus.dp_run}, 32'd0);
      chk("abort_dp_rst_n", {31'd0, bus.dp_rst_n}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_hold_dp_rst_n", {31'd0, bus.dp_rst_n}, 32'd0);
      chk("abort_no_result", {31'd0, bus.res_valid}, 32'd0);
      rst = 1'b0;
      bi[0] = 4'd11; bd[0] = 4'd4; bi[1] = 4'd12; bd[1] = 4'd6;
      do_job(2'b10, 2, 1'b0, 1, 1'b0, "after_abort");
      chk("after_abort_err", {31'd0, err}, 32'd0);
      chk("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
